rr_arbiter_4: RTL and testbench
===============================

# rr_arbiter_4

Four-requester round-robin arbiter that shares a single downstream resource, such as a shared bus or functional unit, between four clients. It issues a registered one-hot grant and a 2-bit encoded grant index. The grant is held while the winner keeps its request asserted, with an optional forced release after a bounded hold time. The block sits between the requesting units and the resource's select input; the encoded index drives the resource's mux select directly.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one grant may be held (legal range 1..255); 0 disables forced release
- CNT_W, 8: width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req  input  4  request per client; client i holds req[i] high for as long as it wants the resource
- gnt  output  4  registered one-hot grant; all zero when no grant is active
- gnt_idx  output  2  binary index of the granted client; valid only while gnt_valid=1, holds its last value otherwise
- gnt_valid  output  1  high while any grant is active (equals OR of gnt)
- preempt  output  1  one-cycle pulse in the cycle a grant is force-released by MAX_HOLD

## Operation
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If req != 0, select the winner by round-robin. Search order is last+1, last+2, last+3, last (mod 4), where last is the most recently granted index.
  - Next cycle: state=GRANT, gnt=one-hot(winner), gnt_idx=winner, hold_cnt=1.
  - If req == 0, remain in IDLE with gnt=0.
- GRANT: while req[gnt_idx]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD), hold the grant and increment hold_cnt (saturating).
- Normal release: req[gnt_idx]=0 sampled.
  - Next cycle: gnt=0, state=IDLE, last=gnt_idx.
- Forced release: MAX_HOLD!=0, hold_cnt==MAX_HOLD and req[gnt_idx] still 1.
  - Next cycle: gnt=0, state=IDLE, last=gnt_idx, preempt=1 for that single cycle.
  - The preempted client drops to lowest priority at the next arbitration.
- Requests from non-granted clients are ignored during GRANT. No queuing occurs; clients must keep req high to stay eligible.
- Any req[i] that is not one-hot-exclusive is legal. Arbitration always yields exactly one winner.

## Timing
- Reset (async assert, sync deassert by clk domain): state=IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, preempt=0, hold_cnt=0, last=3. Client 0 therefore has top priority after reset.
- Request-to-grant latency is 1 cycle: req sampled in IDLE at edge N, gnt visible after edge N+1.
- Release-to-regrant:
  - Every release inserts exactly one IDLE cycle with gnt=0.
  - Minimum grant period is 2 cycles (1 granted + 1 idle).
  - No back-to-back grants without an idle gap.
- Release and a new request in the same cycle: the new request is seen in the IDLE cycle and is granted the cycle after.
- With MAX_HOLD=N, a continuously requesting client holds gnt for exactly N cycles and is followed by a one-cycle preempt pulse with gnt=0.
- If reset_n is asserted mid-grant, all outputs clear immediately (asynchronously). After reset the priority pointer restarts at last=3.
- All outputs are registered; there are no combinational paths from req to any output.

## Structure
- Shared package arb_pkg:
  - state encoding ST_IDLE=1'b0, ST_GRANT=1'b1
  - NUM_REQ=4
  - IDX_W=2
- Sub-module onehot4_to_bin: a combinational one-hot (4) to binary (2) encoder that produces gnt_idx from the next-grant vector. Non-one-hot input gives don't-care output. It is instantiated once, in front of the gnt_idx register.
- Round-robin search is implemented as a rotate-by-(last+1), fixed-priority pick, then rotate back.

## Test plan
- Reset, then req=4'b1111 held with MAX_HOLD=0 -> gnt=0001 indefinitely, gnt_idx=0. Drop req[0] -> one idle cycle, then gnt=0010, gnt_idx=1.
- req=4'b1111 held, each winner drops its req after 3 cycles then reasserts -> grant order 0,1,2,3,0. Each grant lasts 3 cycles, separated by 1 idle cycle.
- MAX_HOLD=4, req=4'b0100 held constantly -> gnt=0100 for 4 cycles, preempt=1 with gnt=0 for 1 cycle, then gnt=0100 again (sole requester).
- MAX_HOLD=4, req=4'b0101 held -> alternating grants 0,2,0,2, each lasting 4 cycles with a preempt pulse between them.
- Assert reset_n=0 mid-grant (gnt=1000) -> gnt=0, gnt_valid=0 and gnt_idx=00 without waiting for clk. After release with req=4'b1001, the first grant goes to client 0.
- req pulses high for 1 cycle only while another client is granted -> never granted. Verify gnt is always one-hot or zero and gnt_valid==|gnt every cycle.

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Shared types, sizes and the round-robin pick function for the 4-way arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Round-robin winner as a one-hot vector. The requests are rotated so that
  // index last+1 lands on bit 0. A fixed lowest-bit-first pick is made, and
  // the pick is rotated back to the real client positions.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W:0]       sh;
    sh   = {1'b0, last} + 1'b1;
    dbl  = {req, req} >> sh;
    rot  = dbl[NUM_REQ-1:0];
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    dbl = {pick, pick} << sh;
    return dbl[2*NUM_REQ-1:NUM_REQ];
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the four clients and the arbiter.
interface rr_arbiter_4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               preempt;

  // Client side: drives requests, observes grants.
  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  preempt
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output preempt
  );
endinterface

// File: rtl/rr_arbiter_4_onehot4_to_bin.sv
// One-hot (4) to binary (2) encoder; output is meaningless for non-one-hot input.
module onehot4_to_bin
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot_i,
  output logic [IDX_W-1:0]   bin_o
);
  assign bin_o[0] = onehot_i[1] | onehot_i[3];
  assign bin_o[1] = onehot_i[2] | onehot_i[3];
endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter. The grant is held while the winner keeps
// requesting, with an optional forced release after MAX_HOLD cycles.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  rr_arbiter_4_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam bit               HOLD_EN  = (MAX_HOLD != 0);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q;
  logic               preempt_q, preempt_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   enc_idx;

  // The index register is fed from the next-grant vector, so it updates in
  // step with gnt and keeps its old value once the grant goes away.
  onehot4_to_bin u_enc (
    .onehot_i (gnt_d),
    .bin_o    (enc_idx)
  );

  assign gnt_idx_d = (|gnt_d) ? enc_idx : gnt_idx_q;

  // Next-state logic: arbitrate in IDLE; hold, release or preempt in GRANT.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    last_d    = last_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (|bus.req) begin
          gnt_d   = rr_pick(bus.req, last_q);
          state_d = ST_GRANT;
          hold_d  = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (!bus.req[gnt_idx_q]) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
          last_d  = gnt_idx_q;
          hold_d  = '0;
        end else if (HOLD_EN && (hold_q >= HOLD_MAX)) begin
          // The winner is still requesting but has used up its slot. Recording
          // it as last drops it to lowest priority for the next arbitration.
          gnt_d     = '0;
          state_d   = ST_IDLE;
          last_d    = gnt_idx_q;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else if (hold_q != {CNT_W{1'b1}}) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; last resets to 3 so client 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      hold_q      <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= |gnt_d;
      preempt_q   <= preempt_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: one instance without forced release and
// one with MAX_HOLD=4, both sharing clock and reset.
module tb_rr_arbiter_4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  rr_arbiter_4_if if_nh ();
  rr_arbiter_4_if if_h4 ();

  rr_arbiter_4 #(.MAX_HOLD(0), .CNT_W(8)) dut_nh (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_nh.slave)
  );

  rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(8)) dut_h4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_h4.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Full output check of one instance (sel=0: no hold limit, sel=1: MAX_HOLD=4).
  task automatic expect_out(input bit sel, input string tag, input logic [3:0] g,
                            input logic [1:0] idx, input logic pre);
    logic [3:0] ag;
    logic [1:0] ai;
    logic       av;
    logic       ap;
    ag = sel ? if_h4.gnt       : if_nh.gnt;
    ai = sel ? if_h4.gnt_idx   : if_nh.gnt_idx;
    av = sel ? if_h4.gnt_valid : if_nh.gnt_valid;
    ap = sel ? if_h4.preempt   : if_nh.preempt;
    check_val({tag, ".gnt"},       8'(ag), 8'(g));
    check_val({tag, ".gnt_idx"},   8'(ai), 8'(idx));
    check_val({tag, ".gnt_valid"}, 8'(av), 8'(|g));
    check_val({tag, ".preempt"},   8'(ap), 8'(pre));
    $display("[%0t] %s dut=%0d gnt=%b idx=%0d valid=%b preempt=%b", $time, tag, sel, ag, ai, av, ap);
  endtask

  // Grant must be one-hot or zero and gnt_valid must track it every cycle.
  always @(negedge clk) begin
    check_val("inv_nh_onehot0", 8'($onehot0(if_nh.gnt)), 8'd1);
    check_val("inv_nh_valid",   8'(if_nh.gnt_valid),     8'(|if_nh.gnt));
    check_val("inv_h4_onehot0", 8'($onehot0(if_h4.gnt)), 8'd1);
    check_val("inv_h4_valid",   8'(if_h4.gnt_valid),     8'(|if_h4.gnt));
  end

  // Assert reset between clock edges for one cycle; caller releases it.
  task automatic reset_pulse();
    @(negedge clk);
    #2;
    reset_n   = 1'b0;
    if_nh.req = 4'b0000;
    if_h4.req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] one;
    logic [1:0] w;
    logic [1:0] seq4 [4];
    one       = 4'b0001;
    reset_n   = 1'b0;
    if_nh.req = 4'b0000;
    if_h4.req = 4'b0000;

    // Reset state.
    @(negedge clk);
    expect_out(0, "reset_nh", 4'b0000, 2'd0, 1'b0);
    expect_out(1, "reset_h4", 4'b0000, 2'd0, 1'b0);

    // All requesting, no hold limit: client 0 keeps the grant.
    reset_n   = 1'b1;
    if_nh.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_out(0, "t1_hold0", 4'b0001, 2'd0, 1'b0);
    end
    if_nh.req = 4'b1110;
    @(negedge clk);
    expect_out(0, "t1_idle", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    expect_out(0, "t1_gnt1", 4'b0010, 2'd1, 1'b0);

    // Rotation 0,1,2,3,0 with 3-cycle grants and one idle cycle between.
    reset_pulse();
    reset_n   = 1'b1;
    if_nh.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = 2'(k % 4);
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        expect_out(0, "t2_grant", one << w, w, 1'b0);
        if (c == 3) if_nh.req = 4'b1111 & ~(one << w);
      end
      @(negedge clk);
      expect_out(0, "t2_idle", 4'b0000, w, 1'b0);
      if_nh.req = 4'b1111;
    end

    // Sole requester with MAX_HOLD=4: 4 granted, 1 preempt, then again.
    reset_pulse();
    reset_n   = 1'b1;
    if_h4.req = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        expect_out(1, "t3_grant", 4'b0100, 2'd2, 1'b0);
      end
      @(negedge clk);
      expect_out(1, "t3_preempt", 4'b0000, 2'd2, 1'b1);
    end
    @(negedge clk);
    expect_out(1, "t3_regrant", 4'b0100, 2'd2, 1'b0);

    // Two requesters with MAX_HOLD=4 alternate 0,2,0,2.
    reset_pulse();
    reset_n   = 1'b1;
    if_h4.req = 4'b0101;
    seq4[0] = 2'd0; seq4[1] = 2'd2; seq4[2] = 2'd0; seq4[3] = 2'd2;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        expect_out(1, "t4_grant", one << seq4[k], seq4[k], 1'b0);
      end
      @(negedge clk);
      expect_out(1, "t4_preempt", 4'b0000, seq4[k], 1'b1);
    end

    // Asynchronous reset in the middle of a grant to client 3.
    reset_pulse();
    reset_n   = 1'b1;
    if_nh.req = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      expect_out(0, "t5_grant3", 4'b1000, 2'd3, 1'b0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    expect_out(0, "t5_async_clr", 4'b0000, 2'd0, 1'b0);
    if_nh.req = 4'b1001;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    expect_out(0, "t5_after_rst", 4'b0001, 2'd0, 1'b0);

    // A one-cycle request during someone else's grant is simply lost.
    reset_pulse();
    reset_n   = 1'b1;
    if_nh.req = 4'b0001;
    @(negedge clk);
    expect_out(0, "t6_grant0", 4'b0001, 2'd0, 1'b0);
    if_nh.req = 4'b0101;
    @(negedge clk);
    expect_out(0, "t6_pulse", 4'b0001, 2'd0, 1'b0);
    if_nh.req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      expect_out(0, "t6_hold", 4'b0001, 2'd0, 1'b0);
    end
    if_nh.req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      expect_out(0, "t6_none", 4'b0000, 2'd0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
